// File: rtl/reg_file_pkg.sv
// Shared constants for the register file with pending scoreboard.
package reg_file_pkg;

  localparam int unsigned RD_FIRST   = 0;
  localparam int unsigned WR_FIRST   = 1;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-bit scoreboard: issue marks a destination busy, write-back clears it.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  output logic [2**ADDR_W-1:0] pending,
  output logic [ADDR_W:0]      pend_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             iss_ok, wr_ok, inc, dec;

  assign iss_ok = iss_en && !(ZERO_REG && iss_addr == '0);
  assign wr_ok  = wr_en  && !(ZERO_REG && wr_addr  == '0);

  // Count tracks the pending vector incrementally; an issue to the same
  // address as a write keeps the bit set, so that write must not decrement.
  assign inc = iss_ok && !pend_q[iss_addr];
  assign dec = wr_ok && pend_q[wr_addr] && !(iss_ok && iss_addr == wr_addr);

  always_comb begin
    pend_d = pend_q;
    if (wr_ok)  pend_d[wr_addr]  = 1'b0;
    if (iss_ok) pend_d[iss_addr] = 1'b1;
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending  = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// 2R1W register file with registered read ports and a hazard scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned BYPASS   = RD_FIRST,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd0_ready,
  output logic              rd1_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_ok;
  logic [DATA_W:0]   rd0_d, rd1_d;
  logic [DATA_W-1:0] rd0_data_q, rd1_data_q;
  logic              rd0_ready_q, rd1_ready_q;

  assign wr_ok = wr_en && !(ZERO_REG && wr_addr == '0);

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .pending  (pending),
    .pend_cnt (pend_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Returns {ready, data}; the zero-register check is last so it beats bypass.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    r = {~pending[a], regs_q[a]};
    if (BYPASS == WR_FIRST && wr_en && wr_addr == a) r = {1'b1, wr_data};
    if (ZERO_REG && a == '0) r = {1'b1, DATA_W'(0)};
    return r;
  endfunction

  always_comb begin
    rd0_d = read_port(rd0_addr);
    rd1_d = read_port(rd1_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
      rd0_ready_q <= 1'b1;
      rd1_ready_q <= 1'b1;
    end else if (rd_en) begin
      rd0_data_q  <= rd0_d[DATA_W-1:0];
      rd1_data_q  <= rd1_d[DATA_W-1:0];
      rd0_ready_q <= rd0_d[DATA_W];
      rd1_ready_q <= rd1_d[DATA_W];
    end
  end

  assign rd0_data  = rd0_data_q;
  assign rd1_data  = rd1_data_q;
  assign rd0_ready = rd0_ready_q;
  assign rd1_ready = rd1_ready_q;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file: two read ports, one write port.
- Adds a per-register pending scoreboard for hazard tracking between issue and write-back.
- Read-first or write-first (bypass) collision mode, selected by parameter.
- Optional hardwired zero register (MIPS $0).
- Sits between decode (issue/read) and write-back in the pipeline.

Parameters:
- DATA_W, 32, data width in bits; values are signed two's complement.
- ADDR_W, 5, address width; depth is 2**ADDR_W.
- BYPASS, 0, collision mode: 0 = read-first (old data), 1 = write-first (new data forwarded).
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and issues.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rd_en  in  1  read strobe; captures both read ports this cycle.
- rd0_addr  in  ADDR_W  read port 0 address.
- rd1_addr  in  ADDR_W  read port 1 address.
- rd0_data  out  DATA_W  registered read data, port 0.
- rd1_data  out  DATA_W  registered read data, port 1.
- rd0_ready  out  1  registered; 1 = register was not pending when read.
- rd1_ready  out  1  registered; 1 = register was not pending when read.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- iss_en  in  1  issue strobe; marks a destination register as pending.
- iss_addr  in  ADDR_W  destination register being issued.
- pend_cnt  out  ADDR_W+1  registered count of pending registers.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - All registers cleared to 0; all pending bits cleared.
  - rd0_data, rd1_data and pend_cnt go to 0; rd0_ready and rd1_ready go to 1.
  - Reset overrides every strobe asserted in the same cycle.
  - Reset mid-operation discards all in-flight pending state.
- Write: wr_en=1 → regs[wr_addr] <= wr_data at the edge; pending[wr_addr] cleared.
- Read:
  - rd_en=1 → rdN_data and rdN_ready updated at the edge; latency 1 cycle.
  - rd_en=0 → all read outputs hold their previous values.
- Read/write collision on the same address in the same cycle:
  - BYPASS=0: rdN_data = old contents; rdN_ready = !pending before the write.
  - BYPASS=1: rdN_data = wr_data; rdN_ready = 1.
  - Both read ports may hit the same address; each port resolves independently.
- Issue: iss_en=1 → pending[iss_addr] set at the edge.
- Issue and write to the same address in the same cycle: issue wins; pending stays or becomes 1, data is still written.
- A read in the same cycle as an issue to the same address sees the pre-issue pending value.
- pend_cnt:
  - Always equals the population count of the pending bits after the edge.
  - Updated incrementally: +1 if issue sets a clear bit; −1 if a write clears a set bit and no issue hits that address; 0 net when both apply to different addresses.
  - Never wraps: the maximum is 2**ADDR_W (or 2**ADDR_W−1 with ZERO_REG=1).
- Issuing an already-pending register → no count change.
- Writing a non-pending register → data written, no count change.
- ZERO_REG=1, address 0:
  - Writes are dropped and issues are ignored.
  - Reads return data 0, ready 1, regardless of BYPASS.
- No X propagation: reading an unwritten register returns 0.

Decomposition:
- Package reg_file_pkg:
  - RD_FIRST=0 and WR_FIRST=1 constants.
  - Default width constants DATA_W_DEF=32 and ADDR_W_DEF=5.
- Sub-module reg_file_scoreboard (parameter ADDR_W, ZERO_REG):
  - Holds the pending bit vector and the pend_cnt counter.
  - Inputs: clk, rst, iss_en/iss_addr, wr_en/wr_addr.
  - Exposes the pending vector to the read path.
- The top level holds the data array, read registers and collision mux.

Test Plan:
- Reset then read: rst for 1 edge, rd_en=1, rd0_addr=3, rd1_addr=7 → next cycle rd0_data=0, rd1_data=0, both ready=1, pend_cnt=0.
- Write then read: wr 0x155 to r2; next cycle rd_en=1, rd0_addr=2 → rd0_data=0x155, rd0_ready=1.
- Collision mode: r4=0x10; same cycle wr r4=0x22 and rd0_addr=4.
  - BYPASS=0 → rd0_data=0x10.
  - BYPASS=1 → rd0_data=0x22.
  - A following read of r4 → 0x22 in both modes.
- Scoreboard sequence:
  - iss r5, iss r6 → pend_cnt=2.
  - rd r5 → rd0_ready=0.
  - wr r5 and iss r9 in the same cycle → pend_cnt=2.
  - wr r6, wr r9 → pend_cnt=0.
  - rd r5 → ready=1.
- Issue/write race: r8 pending; same cycle iss_en and wr_en on r8 with wr_data=0x3 → pending stays, pend_cnt unchanged; next read returns 0x3 with ready=0.
- Zero register plus reset mid-operation:
  - wr r0=0xFF and iss r0 → read r0 gives 0, ready=1, pend_cnt=0.
  - iss r1, r2, then assert rst → pend_cnt=0, r1 reads 0.
